// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz VGA timing constants and the raster position type.
package vga_pkg;

  localparam int unsigned POS_W = 10;

  localparam int unsigned DEF_CLK_DIV   = 2;
  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  localparam int unsigned DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int unsigned DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int unsigned DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  // Raster position as consumed by paint_VGA.
  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
  } vga_pos_t;

  // Half-open window test lo <= v < hi.
  function automatic logic in_window(input logic [POS_W-1:0] v,
                                     input logic [POS_W-1:0] lo,
                                     input logic [POS_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_if.sv
// Video output bundle: raster position for paint_VGA plus the DAC sync/blank/clock pins.
interface vga_if;
  import vga_pkg::*;

  logic [POS_W-1:0] X;
  logic [POS_W-1:0] Y;
  logic             hsync;
  logic             vsync;
  logic             blank_n;
  logic             sync_n;
  logic             vga_clk;
  logic             line_start;
  logic             frame_start;

  modport master (
    output X, Y, hsync, vsync, blank_n, sync_n, vga_clk, line_start, frame_start
  );

  modport slave (
    input X, Y, hsync, vsync, blank_n, sync_n, vga_clk, line_start, frame_start
  );

endinterface

// File: rtl/vga_pixel_tick.sv
// Pixel-rate divider: pix_tick flags the last clk of each pixel, vga_clk is high
// for the second half of the pixel so the DAC samples mid-pixel.
module vga_pixel_tick #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic pix_tick_o,
  output logic vga_clk_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("vga_pixel_tick: CLK_DIV must be at least 2");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_tick_q;
  logic             vga_clk_q;

  // Divider parks at 0 while disabled so the first pixel gets a full period.
  always_comb begin
    div_d = '0;
    if (en_i && (div_q != DIV_LAST)) begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      pix_tick_q <= 1'b0;
      vga_clk_q  <= 1'b0;
    end else begin
      div_q      <= div_d;
      pix_tick_q <= (div_d == DIV_LAST);
      vga_clk_q  <= (div_d >= DIV_HALF);
    end
  end

  assign pix_tick_o = pix_tick_q;
  assign vga_clk_o  = vga_clk_q;

endmodule

// File: rtl/vga_controller.sv
// VGA raster generator: X/Y counters with registered sync, blank and line/frame
// markers, all decoded from the next state so they switch on the same edge as X/Y.
module vga_controller
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK
) (
  input  logic  clk,
  input  logic  rst,
  vga_if.master vga_o
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [POS_W-1:0] X_LAST   = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] Y_LAST   = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W-1:0] X_VIS    = POS_W'(H_VISIBLE);
  localparam logic [POS_W-1:0] Y_VIS    = POS_W'(V_VISIBLE);
  localparam logic [POS_W-1:0] HS_START = POS_W'(H_VISIBLE + H_FRONT);
  localparam logic [POS_W-1:0] HS_END   = POS_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [POS_W-1:0] VS_START = POS_W'(V_VISIBLE + V_FRONT);
  localparam logic [POS_W-1:0] VS_END   = POS_W'(V_VISIBLE + V_FRONT + V_SYNC);

  if ((H_TOTAL > (1 << POS_W)) || (V_TOTAL > (1 << POS_W))) begin : g_bad_geom
    $error("vga_controller: raster does not fit the position counters");
  end

  logic     run_q;
  logic     pix_tick;
  logic     vga_clk;
  vga_pos_t pos_q, pos_d;
  logic     hsync_q, hsync_d;
  logic     vsync_q, vsync_d;
  logic     blank_n_q, blank_n_d;
  logic     line_start_q, line_start_d;
  logic     frame_start_q, frame_start_d;

  vga_pixel_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick (
    .clk        (clk),
    .rst        (rst),
    .en_i       (run_q),
    .pix_tick_o (pix_tick),
    .vga_clk_o  (vga_clk)
  );

  // The first edge out of reset loads pixel (0,0) with its decode live.
  always_comb begin
    pos_d = pos_q;
    if (!run_q) begin
      pos_d = '0;
    end else if (pix_tick) begin
      if (pos_q.x == X_LAST) begin
        pos_d.x = '0;
        pos_d.y = (pos_q.y == Y_LAST) ? '0 : pos_q.y + POS_W'(1);
      end else begin
        pos_d.x = pos_q.x + POS_W'(1);
      end
    end

    hsync_d       = !in_window(pos_d.x, HS_START, HS_END);
    vsync_d       = !in_window(pos_d.y, VS_START, VS_END);
    blank_n_d     = (pos_d.x < X_VIS) && (pos_d.y < Y_VIS);
    line_start_d  = (pos_d.x == '0);
    frame_start_d = (pos_d.x == '0) && (pos_d.y == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q         <= 1'b0;
      pos_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_n_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      run_q         <= 1'b1;
      pos_q         <= pos_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_n_q     <= blank_n_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_o.X           = pos_q.x;
  assign vga_o.Y           = pos_q.y;
  assign vga_o.hsync       = hsync_q;
  assign vga_o.vsync       = vsync_q;
  assign vga_o.blank_n     = blank_n_q;
  assign vga_o.sync_n      = 1'b0;
  assign vga_o.vga_clk     = vga_clk;
  assign vga_o.line_start  = line_start_q;
  assign vga_o.frame_start = frame_start_q;

endmodule
